// File: rtl/controller_pkg.sv
// Shared definitions for the gamepad controller window: poll FSM encoding
// and button bit positions within each pad register.
package controller_pkg;

    localparam int NUM_BUTTONS = 8;

    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/controller_interface_m_if.sv
// CPU-side control strobes, poll request/busy and the serial pad lines,
// bundled so the controller and its neighbours share one connection point.
interface controller_interface_m_if;
    import controller_pkg::*;

    // start is a one-cycle request honoured only while busy is low; busy stays
    // high from the cycle after start until the button registers have updated.
    logic   start;
    logic   busy;
    logic   SELECT_controller;
    logic   write_enable;
    logic   port_sel;
    logic   ctrl_latch;
    logic   ctrl_clk;
    logic   ctrl_data0;
    logic   ctrl_data1;
    state_t dbg_state;

    modport slave (
        input  start, SELECT_controller, write_enable, port_sel, ctrl_data0, ctrl_data1,
        output busy, ctrl_latch, ctrl_clk, dbg_state
    );

    modport master (
        output start, SELECT_controller, write_enable, port_sel, ctrl_data0, ctrl_data1,
        input  busy, ctrl_latch, ctrl_clk, dbg_state
    );

endinterface

// File: rtl/controller_tick_m.sv
// Loadable down-counter: load it with (length - 1) and o_tc is high on the
// final cycle of that length.
module controller_tick_m #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_last,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_last;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/controller_interface_m.sv
// Polls two serial gamepads on request and serves their button bytes to the
// CPU data bus while the controller window is selected for reading.
module controller_interface_m
    import controller_pkg::*;
#(
    parameter int CLK_DIV = 75
) (
    input  logic                     clk_12_5875,
    input  logic                     rst,
    inout  wire  [NUM_BUTTONS-1:0]   data,
    controller_interface_m_if.slave  bus
);

    localparam int CW = $clog2(2 * CLK_DIV);

    state_t                 r_state;
    state_t                 w_next;
    logic [2:0]             r_bit;
    logic [NUM_BUTTONS-1:0] r_shift0;
    logic [NUM_BUTTONS-1:0] r_shift1;
    logic [NUM_BUTTONS-1:0] r_pad0;
    logic [NUM_BUTTONS-1:0] r_pad1;
    logic                   w_load;
    logic [CW-1:0]          w_load_val;
    logic                   w_tc;
    logic [2:0]             w_idx;
    logic                   w_rd_en;
    logic [NUM_BUTTONS-1:0] w_rd_val;

    controller_tick_m #(.W(CW)) u_tick (
        .i_clk   (clk_12_5875),
        .i_rst_n (rst),
        .i_load  (w_load),
        .i_last  (w_load_val),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk_12_5875 or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The divider is reloaded on each transition so every timed state lasts exactly its length.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = CW'(CLK_DIV - 1);
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next     = ST_LATCH;
                    w_load     = 1'b1;
                    w_load_val = CW'(2 * CLK_DIV - 1);
                end
            end
            ST_LATCH: begin
                if (w_tc) begin
                    w_next = ST_LOW;
                    w_load = 1'b1;
                end
            end
            ST_LOW: begin
                if (w_tc) begin
                    if (r_bit == 3'd7) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_HIGH;
                        w_load = 1'b1;
                    end
                end
            end
            ST_HIGH: begin
                if (w_tc) begin
                    w_next = ST_LOW;
                    w_load = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // First bit shifted out is A, which lives in the top bit.
    assign w_idx = 3'(BTN_A) - r_bit;

    always_ff @(posedge clk_12_5875 or negedge rst) begin
        if (!rst) begin
            r_bit    <= '0;
            r_shift0 <= '0;
            r_shift1 <= '0;
            r_pad0   <= '0;
            r_pad1   <= '0;
        end else begin
            if (r_state == ST_LATCH && w_tc) begin
                r_bit <= '0;
            end
            if (r_state == ST_LOW && w_tc) begin
                r_shift0[w_idx] <= bus.ctrl_data0;
                r_shift1[w_idx] <= bus.ctrl_data1;
            end
            if (r_state == ST_HIGH && w_tc) begin
                r_bit <= r_bit + 3'd1;
            end
            // Pad lines are active-low; both registers commit together.
            if (r_state == ST_DONE) begin
                r_pad0 <= ~r_shift0;
                r_pad1 <= ~r_shift1;
            end
        end
    end

    assign bus.ctrl_latch = (r_state == ST_LATCH);
    assign bus.ctrl_clk   = (r_state == ST_HIGH);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.dbg_state  = r_state;

    assign w_rd_en  = bus.SELECT_controller && !bus.write_enable;
    assign w_rd_val = bus.port_sel ? r_pad1 : r_pad0;
    assign data     = w_rd_en ? w_rd_val : {NUM_BUTTONS{1'bz}};

endmodule

// File: tb/tb_controller_interface_m.sv
// Bench for controller_interface_m: two behavioural serial pads, randomized
// button patterns, and poll timing and read coherency derived from the pad protocol.
module tb_controller_interface_m;
    import controller_pkg::*;

    localparam int D           = 4;
    localparam int POLL_CYCLES = 17 * D + 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    wire  [7:0] data;
    logic       tb_oe  = 1'b0;
    logic [7:0] tb_val = 8'h00;

    int total = 0;
    int bad   = 0;

    controller_interface_m_if bus();

    controller_interface_m #(.CLK_DIV(D)) dut (
        .clk_12_5875 (clk),
        .rst         (rst_n),
        .data        (data),
        .bus         (bus)
    );

    assign data = tb_oe ? tb_val : 8'hzz;

    always #5 clk = ~clk;

    // Pad model: latch captures buttons, each rising ctrl_clk advances to the next button.
    logic [7:0] btn0  = 8'h00;
    logic [7:0] btn1  = 8'h00;
    logic       conn0 = 1'b1;
    logic       conn1 = 1'b1;
    logic [2:0] idx   = 3'd7;

    always @(posedge bus.ctrl_latch) idx = 3'd7;
    always @(posedge bus.ctrl_clk) if (idx != 3'd0) idx = idx - 3'd1;

    assign bus.ctrl_data0 = conn0 ? ~btn0[idx] : 1'b1;
    assign bus.ctrl_data1 = conn1 ? ~btn1[idx] : 1'b1;

    // Reference: the register shows pressed buttons (1 = pressed), nothing for a missing pad.
    function automatic logic [7:0] model_reg(input logic [7:0] btn, input logic conn);
        return conn ? btn : 8'h00;
    endfunction

    task automatic read_pad(input logic p, output logic [7:0] v);
        bus.SELECT_controller = 1'b1;
        bus.write_enable      = 1'b0;
        bus.port_sel          = p;
        #1;
        v = data;
        bus.SELECT_controller = 1'b0;
    endtask

    task automatic probe_bus(input logic [7:0] pat, output logic [7:0] v);
        tb_oe  = 1'b1;
        tb_val = pat;
        #1;
        v = data;
        tb_oe = 1'b0;
    endtask

    task automatic run_poll(output int busy_n, output int latch_n, output int clkh_n,
                            output int pulses, output bit timeout);
        logic prev_clk;
        busy_n = 0; latch_n = 0; clkh_n = 0; pulses = 0; timeout = 1'b1;
        prev_clk = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (bus.busy) busy_n++;
            if (bus.ctrl_latch) latch_n++;
            if (bus.ctrl_clk) clkh_n++;
            if (bus.ctrl_clk && !prev_clk) pulses++;
            prev_clk = bus.ctrl_clk;
            if (!bus.busy) begin
                timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst_n = 1'b0;
        #3;
        total++;
        if ({bus.busy, bus.ctrl_latch, bus.ctrl_clk} !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs: busy/latch/clk=%b expected 000", {bus.busy, bus.ctrl_latch, bus.ctrl_clk});
        end
        total++;
        if (bus.dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, ST_IDLE);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            read_pad(p[0], v);
            total++;
            if (v !== 8'h00) begin
                bad++;
                $display("FAIL reset_read pad%0d: got %h expected 00", p, v);
            end
        end
        bus.SELECT_controller = 1'b0;
        probe_bus(8'hC3, v);
        total++;
        if (v !== 8'hC3) begin
            bad++;
            $display("FAIL reset_unselected_bus: got %h expected c3", v);
        end
        @(negedge clk);
    endtask

    task automatic test_single_poll();
        int busy_n, latch_n, clkh_n, pulses;
        bit timeout;
        logic [7:0] v;
        btn0 = 8'h81; btn1 = 8'h00; conn0 = 1'b1; conn1 = 1'b1;
        run_poll(busy_n, latch_n, clkh_n, pulses, timeout);
        total++;
        if (timeout) begin
            bad++;
            $display("FAIL single_timeout: busy never fell");
        end
        total++;
        if (busy_n != POLL_CYCLES) begin
            bad++;
            $display("FAIL single_busy_len: got %0d expected %0d", busy_n, POLL_CYCLES);
        end
        total++;
        if (latch_n != 2 * D) begin
            bad++;
            $display("FAIL single_latch_len: got %0d expected %0d", latch_n, 2 * D);
        end
        total++;
        if (pulses != 7) begin
            bad++;
            $display("FAIL single_clk_pulses: got %0d expected 7", pulses);
        end
        total++;
        if (clkh_n != 7 * D) begin
            bad++;
            $display("FAIL single_clk_high: got %0d expected %0d", clkh_n, 7 * D);
        end
        read_pad(1'b0, v);
        total++;
        if (v !== 8'h81) begin
            bad++;
            $display("FAIL single_pad0: got %h expected 81", v);
        end
        read_pad(1'b1, v);
        total++;
        if (v !== 8'h00) begin
            bad++;
            $display("FAIL single_pad1: got %h expected 00", v);
        end
        @(negedge clk);
    endtask

    task automatic test_random_polls();
        int busy_n, latch_n, clkh_n, pulses;
        bit timeout;
        logic [7:0] v;
        for (int n = 0; n < 6; n++) begin
            btn0  = 8'($urandom_range(0, 255));
            btn1  = 8'($urandom_range(0, 255));
            conn0 = ($urandom_range(0, 3) != 0);
            conn1 = ($urandom_range(0, 3) != 0);
            run_poll(busy_n, latch_n, clkh_n, pulses, timeout);
            total++;
            if (timeout || busy_n != POLL_CYCLES) begin
                bad++;
                $display("FAIL random_busy_len[%0d]: got %0d expected %0d", n, busy_n, POLL_CYCLES);
            end
            read_pad(1'b0, v);
            total++;
            if (v !== model_reg(btn0, conn0)) begin
                bad++;
                $display("FAIL random_pad0[%0d]: got %h expected %h", n, v, model_reg(btn0, conn0));
            end
            read_pad(1'b1, v);
            total++;
            if (v !== model_reg(btn1, conn1)) begin
                bad++;
                $display("FAIL random_pad1[%0d]: got %h expected %h", n, v, model_reg(btn1, conn1));
            end
            @(negedge clk);
        end
        conn0 = 1'b1; conn1 = 1'b1;
    endtask

    task automatic test_coherency();
        int busy_n, latch_n, clkh_n, pulses;
        bit timeout;
        logic [7:0] v, exp_v;
        btn0 = 8'h81; btn1 = 8'h00;
        run_poll(busy_n, latch_n, clkh_n, pulses, timeout);
        @(negedge clk);
        btn0 = 8'hFF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= POLL_CYCLES + 6; k++) begin
            exp_v = (k <= POLL_CYCLES) ? 8'h81 : 8'hFF;
            read_pad(1'b0, v);
            total++;
            if (v !== exp_v) begin
                bad++;
                $display("FAIL coherency_read cycle %0d: got %h expected %h", k, v, exp_v);
            end
            total++;
            if (bus.busy !== (k <= POLL_CYCLES)) begin
                bad++;
                $display("FAIL coherency_busy cycle %0d: got %b expected %b", k, bus.busy, (k <= POLL_CYCLES));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_while_busy();
        logic [7:0] v;
        btn0 = 8'($urandom_range(0, 255));
        btn1 = 8'($urandom_range(0, 255));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            total++;
            if (bus.busy !== (k <= POLL_CYCLES)) begin
                bad++;
                $display("FAIL busy_retrigger cycle %0d: got %b expected %b", k, bus.busy, (k <= POLL_CYCLES));
            end
            bus.start = (k == 10 || k == 40);
            @(negedge clk);
        end
        bus.start = 1'b0;
        read_pad(1'b0, v);
        total++;
        if (v !== model_reg(btn0, conn0)) begin
            bad++;
            $display("FAIL busy_retrigger_pad0: got %h expected %h", v, model_reg(btn0, conn0));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_poll();
        int busy_n, latch_n, clkh_n, pulses;
        bit timeout;
        logic [7:0] v;
        btn0 = 8'hF0; btn1 = 8'h0F;
        run_poll(busy_n, latch_n, clkh_n, pulses, timeout);
        @(negedge clk);
        btn0 = 8'h3C; btn1 = 8'hC3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        // Cycles 37..40 are the high phase of the fourth shift clock.
        for (int k = 1; k < 38; k++) @(negedge clk);
        total++;
        if (bus.ctrl_clk !== 1'b1 || bus.dbg_state !== ST_HIGH) begin
            bad++;
            $display("FAIL midreset_precondition: clk=%b state=%0d expected clk=1 state=%0d", bus.ctrl_clk, bus.dbg_state, ST_HIGH);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.ctrl_latch, bus.ctrl_clk} !== 3'b000) begin
            bad++;
            $display("FAIL midreset_outputs: busy/latch/clk=%b expected 000", {bus.busy, bus.ctrl_latch, bus.ctrl_clk});
        end
        for (int p = 0; p < 2; p++) begin
            read_pad(p[0], v);
            total++;
            if (v !== 8'h00) begin
                bad++;
                $display("FAIL midreset_pad%0d: got %h expected 00", p, v);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        btn0 = 8'($urandom_range(0, 255));
        btn1 = 8'($urandom_range(0, 255));
        run_poll(busy_n, latch_n, clkh_n, pulses, timeout);
        total++;
        if (timeout || busy_n != POLL_CYCLES) begin
            bad++;
            $display("FAIL midreset_repoll_len: got %0d expected %0d", busy_n, POLL_CYCLES);
        end
        read_pad(1'b0, v);
        total++;
        if (v !== btn0) begin
            bad++;
            $display("FAIL midreset_repoll_pad0: got %h expected %h", v, btn0);
        end
        read_pad(1'b1, v);
        total++;
        if (v !== btn1) begin
            bad++;
            $display("FAIL midreset_repoll_pad1: got %h expected %h", v, btn1);
        end
        @(negedge clk);
    endtask

    task automatic test_write();
        int busy_n, latch_n, clkh_n, pulses;
        bit timeout;
        logic [7:0] v;
        btn0 = 8'hA5; btn1 = 8'h3C;
        run_poll(busy_n, latch_n, clkh_n, pulses, timeout);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bus.SELECT_controller = 1'b1;
            bus.write_enable      = 1'b1;
            bus.port_sel          = k[0];
            probe_bus(8'h5A, v);
            total++;
            if (v !== 8'h5A) begin
                bad++;
                $display("FAIL write_bus_driven[%0d]: got %h expected 5a", k, v);
            end
            @(negedge clk);
        end
        bus.SELECT_controller = 1'b0;
        bus.write_enable      = 1'b0;
        bus.port_sel          = 1'b0;
        probe_bus(8'h96, v);
        total++;
        if (v !== 8'h96) begin
            bad++;
            $display("FAIL unselected_bus_driven: got %h expected 96", v);
        end
        read_pad(1'b0, v);
        total++;
        if (v !== 8'hA5) begin
            bad++;
            $display("FAIL write_pad0_kept: got %h expected a5", v);
        end
        read_pad(1'b1, v);
        total++;
        if (v !== 8'h3C) begin
            bad++;
            $display("FAIL write_pad1_kept: got %h expected 3c", v);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.start             = 1'b0;
        bus.SELECT_controller = 1'b0;
        bus.write_enable      = 1'b0;
        bus.port_sel          = 1'b0;
        test_reset();
        test_single_poll();
        test_random_polls();
        test_coherency();
        test_start_while_busy();
        test_reset_mid_poll();
        test_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
